lib_switch_allocator_rr: RTL and testbench

- Per-output round-robin switch allocator that sits directly upstream of the one-hot packet crossbar.
- Takes per-input output requests from the input-buffer head flits and output-ready flags.
- Produces registered one-hot select vectors per output, which drive the crossbar select directly, plus per-input grant pulses that pop the input buffers.
- Used in the router datapath of the mesh/torus network models.

---
 rtl/lib_switch_allocator_rr.sv | 83 ++++++++
 tb/tb_lib_switch_allocator_rr.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lib_switch_allocator_rr.sv
// Per-output round-robin switch allocator feeding a one-hot crossbar.
// Registered select rows per output plus per-input pop pulses, latency one cycle.
module lib_switch_allocator_rr #(
    parameter int N = 5,
    parameter int M = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic [0:N-1][0:M-1]    i_req,
    input  logic [0:M-1]           i_en,
    output logic [0:M-1][0:N-1]    o_sel,
    output logic [0:N-1]           o_input_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [0:M-1][PW-1:0] ptr;
    logic [0:M-1][PW-1:0] ptr_nxt;
    logic [0:N-1][0:M-1]  req_m;
    logic [0:M-1][0:N-1]  gnt;
    logic [0:N-1]         input_grant_nxt;

    // An input being popped this cycle still shows the departing flit's request,
    // so it sits out one arbitration round; multi-hot requests keep only the lowest output.
    always_comb begin
        logic hit;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        req_m = '0;
        for (int j = 0; j < N; j++) begin
            hit = 1'b0;
            for (int k = 0; k < M; k++) begin
                if (!hit && i_req[j][k] && !o_input_grant[j]) begin
                    req_m[j][k] = 1'b1;
                    hit         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        ptr_nxt = ptr;
        for (int k = 0; k < M; k++) begin
            // NOTE: blocking assignments here; found/idx are scratch values read later in the same pass.
            found = 1'b0;
            for (int off = 0; off < N; off++) begin
                idx = int'(ptr[k]) + off;
                if (idx >= N) idx = idx - N;
                if (i_en[k] && !found && req_m[idx][k]) begin
                    found       = 1'b1;
                    gnt[k][idx] = 1'b1;
                    ptr_nxt[k]  = (idx == N - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_comb begin
        input_grant_nxt = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < M; k++) begin
                input_grant_nxt[j] = input_grant_nxt[j] | gnt[k][j];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_sel         <= '0;
            o_input_grant <= '0;
            ptr           <= '0;
        end else if (ce) begin
            o_sel         <= gnt;
            o_input_grant <= input_grant_nxt;
            ptr           <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_lib_switch_allocator_rr.sv
// Scoreboard bench for lib_switch_allocator_rr: directed vectors push expected
// registered outputs; a monitor pops and compares after every rising edge.
module tb_lib_switch_allocator_rr;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int RW = N * M;

    typedef logic [0:N-1][0:M-1] req_t;
    typedef logic [0:M-1][0:N-1] sel_t;
    typedef struct {
        int         id;
        sel_t       sel;
        logic [0:N-1] gnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    req_t         i_req;
    logic [0:M-1] i_en;
    sel_t         o_sel;
    logic [0:N-1] o_input_grant;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    localparam logic [0:M-1] ALL = 5'b11111;

    lib_switch_allocator_rr #(.N(N), .M(M)) dut (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .i_req         (i_req),
        .i_en          (i_en),
        .o_sel         (o_sel),
        .o_input_grant (o_input_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, id, act, exp);
        end
    endtask

    function automatic req_t row(input int j, input logic [0:M-1] bits);
        req_t r;
        r    = '0;
        r[j] = bits;
        return r;
    endfunction

    // Apply one cycle of inputs; ek/ej name the single expected grant (ek<0: idle).
    task automatic step(input logic r, input logic c, input req_t rq, input logic [0:M-1] en,
                        input int ek, input int ej);
        exp_t e;
        reset = r;
        ce    = c;
        i_req = rq;
        i_en  = en;
        e.id  = step_id;
        e.sel = '0;
        e.gnt = '0;
        if (ek >= 0) begin
            e.sel[ek][ej] = 1'b1;
            e.gnt[ej]     = 1'b1;
        end
        q.push_back(e);
        step_id++;
        @(posedge clk);
        #2;
    endtask

    // Monitor: scoreboard pop plus structural invariants after every edge.
    initial begin
        exp_t e;
        logic ok;
        int   cnt;
        logic col;
        forever begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            for (int k = 0; k < M; k++) if (!$onehot0(o_sel[k])) ok = 1'b0;
            for (int j = 0; j < N; j++) begin
                cnt = 0;
                col = 1'b0;
                for (int k = 0; k < M; k++) begin
                    cnt += int'(o_sel[k][j]);
                    col  = col | o_sel[k][j];
                end
                if (cnt > 1 || col != o_input_grant[j]) ok = 1'b0;
            end
            check("invariants", step_id, 64'(ok), 64'(1'b1));
            if (q.size() > 0) begin
                e = q.pop_front();
                check("o_sel", e.id, 64'(o_sel), 64'(e.sel));
                check("o_input_grant", e.id, 64'(o_input_grant), 64'(e.gnt));
            end
        end
    end

    initial begin
        req_t cont, blk, mb;
        cont = row(0, 5'b10000) | row(1, 5'b10000) | row(4, 5'b10000);
        blk  = row(1, 5'b00100) | row(3, 5'b00100);
        mb   = row(0, 5'b01000) | row(2, 5'b01000) | row(3, 5'b01010);

        // Reset with random traffic, then one idle cycle after release.
        step(1'b1, 1'b1, req_t'(RW'($urandom)), M'($urandom), -1, 0);
        step(1'b1, 1'b1, req_t'(RW'($urandom)), M'($urandom), -1, 0);
        step(1'b0, 1'b1, '0, ALL, -1, 0);

        // Single request: input 2 -> output 3, stale mask forces a gap.
        step(1'b0, 1'b1, row(2, 5'b00010), ALL, 3, 2);
        step(1'b0, 1'b1, row(2, 5'b00010), ALL, -1, 0);
        step(1'b0, 1'b1, row(2, 5'b00010), ALL, 3, 2);
        step(1'b0, 1'b1, '0, ALL, -1, 0);

        // Contention on output 0 by inputs 0, 1, 4.
        step(1'b0, 1'b1, cont, ALL, 0, 0);
        step(1'b0, 1'b1, cont, ALL, 0, 1);
        step(1'b0, 1'b1, cont, ALL, 0, 4);
        step(1'b0, 1'b1, cont, ALL, 0, 0);
        step(1'b0, 1'b1, cont, ALL, 0, 1);
        // Reset mid-contention with ce low still clears; pointer returns to 0.
        step(1'b1, 1'b0, cont, ALL, -1, 0);
        step(1'b0, 1'b1, cont, ALL, 0, 0);
        step(1'b0, 1'b1, cont, ALL, 0, 1);
        step(1'b0, 1'b1, '0, ALL, -1, 0);

        // Blocked output 2 for four cycles, then released.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, blk, 5'b11011, -1, 0);
        step(1'b0, 1'b1, blk, ALL, 2, 1);
        step(1'b0, 1'b1, blk, ALL, 2, 3);
        step(1'b0, 1'b1, blk, ALL, 2, 1);
        step(1'b0, 1'b1, '0, ALL, -1, 0);

        // Multi-bit request from input 3 resolves to output 1 only.
        step(1'b0, 1'b1, row(3, 5'b01010), ALL, 1, 3);
        step(1'b0, 1'b1, row(3, 5'b01010), ALL, -1, 0);
        step(1'b0, 1'b1, row(3, 5'b01010), ALL, 1, 3);
        step(1'b0, 1'b1, '0, ALL, -1, 0);

        // Rotation on output 1 (ptr=4), frozen by ce=0, then resumed in order.
        step(1'b0, 1'b1, mb, ALL, 1, 0);
        step(1'b0, 1'b1, mb, ALL, 1, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, req_t'(RW'($urandom)), M'($urandom), 1, 2);
        step(1'b0, 1'b1, mb, ALL, 1, 3);
        step(1'b0, 1'b1, mb, ALL, 1, 0);
        step(1'b0, 1'b1, mb, ALL, 1, 2);
        step(1'b0, 1'b1, '0, ALL, -1, 0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drain", step_id, 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
